spi_bus_arbiter: RTL and testbench
==================================

// Module: spi_bus_arbiter
// PURPOSE
// Shares the single SPI link to the MCU (SPIDo, SPIClkRunning, SPIClkStretch,
// nMCUSel) between NUM_REQ SPI-master clients, e.g. the RTC bridge and the MCU
// command port. Uses round-robin grants and enforces a chip-select gap between
// owners. A stretch watchdog revokes the bus from a client that stalls it.
// SPIDi is fanned out to all clients outside this block.
// PARAMETERS
// NUM_REQ     2     number of requesting clients (2..8)
// GAP_CYCLES  2     SClk cycles with nMCUSel high after an ownership ends (>=1)
// TIMEOUT     4096  max consecutive owner ClkStretch cycles; 0 disables the watchdog
// PORTS
// SClk           in   1        system clock; all state changes on posedge
// Reset          in   1        asynchronous, active-high reset
// Req            in   NUM_REQ  client i requests the bus; held until its transfer ends
// Grant          out  NUM_REQ  one-hot (or zero) registered grant
// ReqSel         in   NUM_REQ  client i wants chip select asserted (active-high)
// ReqDo          in   NUM_REQ  client i serial data out
// ReqClkRunning  in   NUM_REQ  client i requests SPI clock
// ReqClkStretch  in   NUM_REQ  client i requests clock stretch
// SPIDo          out  1        muxed serial data to MCU
// SPIClkRunning  out  1        muxed clock-run request
// SPIClkStretch  out  1        muxed clock-stretch request
// nMCUSel        out  1        MCU chip select, active-low
// Owner          out  3        index of current/last owner
// TimeoutErr     out  1        sticky: watchdog has fired
// ClearErr       in   1        synchronous clear of TimeoutErr (priority over set)
// BEHAVIOUR
// - Reset values: state=IDLE, Grant=0, last_owner=NUM_REQ-1, Owner=NUM_REQ-1,
//   TimeoutErr=0, gap/stretch counters 0. Combinational outputs while not OWNED:
//   nMCUSel=1, SPIDo=0, SPIClkRunning=0, SPIClkStretch=0.
//   Reset mid-transfer forces these values immediately (async).
// - FSM IDLE -> OWNED -> GAP -> IDLE.
// - IDLE: if Req!=0, pick the first set bit searching from last_owner+1 upward,
//   wrapping modulo NUM_REQ. On that edge: Owner<=pick, last_owner<=pick,
//   Grant<=onehot(pick), state<=OWNED. Req sampled at edge k gives Grant high
//   after edge k. Simultaneous requests are resolved only by round-robin order.
// - OWNED: zero-latency combinational mux from the registered Owner:
//   nMCUSel=~ReqSel[Owner], SPIDo=ReqDo[Owner],
//   SPIClkRunning=ReqClkRunning[Owner], SPIClkStretch=ReqClkStretch[Owner].
//   Req from non-owners is ignored (held pending, no preemption).
// - OWNED exit on Req[Owner]==0: Grant<=0, state<=GAP, gap_cnt<=0.
// - Watchdog (TIMEOUT>0): stretch_cnt increments each OWNED cycle with
//   ReqClkStretch[Owner]=1. It clears on any cycle with stretch=0 and on OWNED
//   entry, and saturates at TIMEOUT.
//   When stretch_cnt==TIMEOUT-1 and stretch is still 1: TimeoutErr<=1,
//   Grant<=0, state<=GAP. This is the TIMEOUT-th consecutive stretch cycle.
//   The revoked client keeps Req high and re-enters round-robin after the gap.
//   It gets no priority boost.
// - GAP: outputs at idle values; gap_cnt++ per cycle. When
//   gap_cnt==GAP_CYCLES-1: state<=IDLE. nMCUSel is therefore high for
//   GAP_CYCLES cycles plus one IDLE arbitration cycle.
// - Req[Owner] dropping and timeout in the same cycle: take the timeout path
//   (TimeoutErr set).
// - ClearErr and a timeout in the same cycle: TimeoutErr ends the cycle 0.
// - Counter widths are $clog2(TIMEOUT+1) and $clog2(GAP_CYCLES+1).
//   No wrap is possible because both counters saturate or reset.
// - Grant is registered and glitch-free. Mux outputs follow client signals
//   combinationally. Clients must drive ReqSel etc. from SClk registers.
// TESTING
// - Reset, then Req=01 at edge 1 -> Grant=01 after edge 1; ReqSel0=1 ->
//   nMCUSel=0 the same cycle; ReqDo0 toggling appears on SPIDo.
// - Req=11 from IDLE after reset -> Grant=01. Drop Req0 -> Grant=00, nMCUSel
//   high for 2 GAP + 1 IDLE cycles -> Grant=10. Re-raise Req0 while 1 owns ->
//   no preemption.
// - Owner 1 drops Req with Req0 still pending -> next grant is 0 (round-robin
//   wrap, last_owner=1).
// - TIMEOUT=8, owner holds ClkStretch=1 for 8 cycles -> TimeoutErr=1, Grant=0,
//   SPIClkStretch=0 after edge 8. With 7 cycles, one low, then 7 more -> no
//   timeout. ClearErr pulse -> TimeoutErr=0.
// - Assert Reset mid-OWNED with nMCUSel=0 -> nMCUSel=1 and Grant=0 without a
//   clock edge. After release, Req=10 -> Grant=10 (last_owner reset to 1, so
//   search starts at 0 and finds 1).

Source files
------------

// File: rtl/spi_bus_arbiter.sv
// spi_bus_arbiter: round-robin owner of the single SPI link to the MCU,
// with a chip-select gap between owners and a clock-stretch watchdog.
// Ports:
//   SClk, Reset (async, active-high), ClearErr
//   Req/ReqSel/ReqDo/ReqClkRunning/ReqClkStretch [NUM_REQ] client inputs
//   Grant [NUM_REQ] registered one-hot grant, Owner [3] current/last owner
//   SPIDo, SPIClkRunning, SPIClkStretch, nMCUSel muxed link outputs
//   TimeoutErr sticky watchdog flag
module spi_bus_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int GAP_CYCLES = 2,
    parameter int TIMEOUT    = 4096
) (
    input  logic               SClk,
    input  logic               Reset,
    input  logic [NUM_REQ-1:0] Req,
    output logic [NUM_REQ-1:0] Grant,
    input  logic [NUM_REQ-1:0] ReqSel,
    input  logic [NUM_REQ-1:0] ReqDo,
    input  logic [NUM_REQ-1:0] ReqClkRunning,
    input  logic [NUM_REQ-1:0] ReqClkStretch,
    output logic               SPIDo,
    output logic               SPIClkRunning,
    output logic               SPIClkStretch,
    output logic               nMCUSel,
    output logic [2:0]         Owner,
    output logic               TimeoutErr,
    input  logic               ClearErr
);

    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam int SW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit WD_EN = (TIMEOUT > 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_OWNED = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [NUM_REQ-1:0]   r_grant;
    logic [2:0]           r_owner;
    logic [2:0]           r_last;
    logic [GW-1:0]        r_gap_cnt;
    logic [SW-1:0]        r_str_cnt;
    logic                 r_err;

    logic [2:0]           w_pick;
    logic                 w_req_own;
    logic                 w_sel_own;
    logic                 w_do_own;
    logic                 w_run_own;
    logic                 w_str_own;
    logic                 w_timeout;
    logic                 w_gap_done;

    // Round-robin pick: smallest distance past last owner, modulo NUM_REQ.
    always_comb begin : p_pick
        int v_best;
        int v_d;
        v_best = NUM_REQ;
        v_d    = 0;
        w_pick = r_last;
        for (int j = 0; j < NUM_REQ; j++) begin
            v_d = (j + 2 * NUM_REQ - int'(r_last) - 1) % NUM_REQ;
            if (Req[j] && (v_d < v_best)) begin
                v_best = v_d;
                w_pick = 3'(j);
            end
        end
    end

    // Owner-indexed view of the client signals.
    always_comb begin
        w_req_own = 1'b0;
        w_sel_own = 1'b0;
        w_do_own  = 1'b0;
        w_run_own = 1'b0;
        w_str_own = 1'b0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (r_owner == 3'(j)) begin
                w_req_own = Req[j];
                w_sel_own = ReqSel[j];
                w_do_own  = ReqDo[j];
                w_run_own = ReqClkRunning[j];
                w_str_own = ReqClkStretch[j];
            end
        end
    end

    // TIMEOUT-th consecutive stretch cycle: counter already holds TIMEOUT-1.
    assign w_timeout = WD_EN && (r_state == S_OWNED) && w_str_own &&
                       (r_str_cnt == SW'(TIMEOUT - 1));
    assign w_gap_done = (r_gap_cnt == GW'(GAP_CYCLES - 1));

    always_ff @(posedge SClk or posedge Reset) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        nMCUSel       = 1'b1;
        SPIDo         = 1'b0;
        SPIClkRunning = 1'b0;
        SPIClkStretch = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (|Req) w_next = S_OWNED;
            end
            S_OWNED: begin
                nMCUSel       = ~w_sel_own;
                SPIDo         = w_do_own;
                SPIClkRunning = w_run_own;
                SPIClkStretch = w_str_own;
                if (w_timeout || !w_req_own) w_next = S_GAP;
            end
            S_GAP: begin
                if (w_gap_done) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge SClk or posedge Reset) begin
        if (Reset) begin
            r_grant   <= '0;
            r_owner   <= 3'(NUM_REQ - 1);
            r_last    <= 3'(NUM_REQ - 1);
            r_gap_cnt <= '0;
            r_str_cnt <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_str_cnt <= '0;
                    if (|Req) begin
                        r_owner <= w_pick;
                        r_last  <= w_pick;
                        r_grant <= NUM_REQ'(1) << w_pick;
                    end
                end
                S_OWNED: begin
                    if (w_timeout || !w_req_own) begin
                        r_grant   <= '0;
                        r_gap_cnt <= '0;
                    end
                    if (!w_str_own) begin
                        r_str_cnt <= '0;
                    end else if (r_str_cnt != SW'(TIMEOUT)) begin
                        r_str_cnt <= r_str_cnt + 1'b1;
                    end
                end
                S_GAP: begin
                    r_str_cnt <= '0;
                    if (!w_gap_done) r_gap_cnt <= r_gap_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Clear wins over a same-cycle watchdog fire.
    always_ff @(posedge SClk or posedge Reset) begin
        if (Reset) begin
            r_err <= 1'b0;
        end else if (ClearErr) begin
            r_err <= 1'b0;
        end else if (w_timeout) begin
            r_err <= 1'b1;
        end
    end

    assign Grant      = r_grant;
    assign Owner      = r_owner;
    assign TimeoutErr = r_err;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// tb_spi_bus_arbiter: directed checks of grant order, gap, mux,
// watchdog and async reset for spi_bus_arbiter (NUM_REQ=2, TIMEOUT=8).
module tb_spi_bus_arbiter;

    logic       SClk = 1'b0;
    logic       Reset;
    logic [1:0] Req;
    logic [1:0] Grant;
    logic [1:0] ReqSel;
    logic [1:0] ReqDo;
    logic [1:0] ReqClkRunning;
    logic [1:0] ReqClkStretch;
    logic       SPIDo;
    logic       SPIClkRunning;
    logic       SPIClkStretch;
    logic       nMCUSel;
    logic [2:0] Owner;
    logic       TimeoutErr;
    logic       ClearErr;

    int checks = 0;
    int errors = 0;

    spi_bus_arbiter #(
        .NUM_REQ(2),
        .GAP_CYCLES(2),
        .TIMEOUT(8)
    ) dut (
        .SClk(SClk),
        .Reset(Reset),
        .Req(Req),
        .Grant(Grant),
        .ReqSel(ReqSel),
        .ReqDo(ReqDo),
        .ReqClkRunning(ReqClkRunning),
        .ReqClkStretch(ReqClkStretch),
        .SPIDo(SPIDo),
        .SPIClkRunning(SPIClkRunning),
        .SPIClkStretch(SPIClkStretch),
        .nMCUSel(nMCUSel),
        .Owner(Owner),
        .TimeoutErr(TimeoutErr),
        .ClearErr(ClearErr)
    );

    always #5 SClk = ~SClk;

    task automatic tick();
        @(posedge SClk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        Reset         = 1'b1;
        Req           = 2'b00;
        ReqSel        = 2'b00;
        ReqDo         = 2'b00;
        ReqClkRunning = 2'b00;
        ReqClkStretch = 2'b00;
        ClearErr      = 1'b0;
        tick();
        tick();
        chk("rst_grant", 32'(Grant), 32'h0);
        chk("rst_nsel", 32'(nMCUSel), 32'h1);
        chk("rst_owner", 32'(Owner), 32'h1);
        chk("rst_err", 32'(TimeoutErr), 32'h0);
        chk("rst_do", 32'(SPIDo), 32'h0);
        Reset = 1'b0;
        tick();

        // single request, mux follows owner 0
        Req = 2'b01;
        tick();
        chk("t1_grant", 32'(Grant), 32'h1);
        chk("t1_nsel_hi", 32'(nMCUSel), 32'h1);
        ReqSel = 2'b01;
        #1;
        chk("t1_nsel_lo", 32'(nMCUSel), 32'h0);
        ReqDo = 2'b01;
        #1;
        chk("t1_do1", 32'(SPIDo), 32'h1);
        ReqDo = 2'b10;
        #1;
        chk("t1_do0", 32'(SPIDo), 32'h0);
        ReqClkRunning = 2'b01;
        #1;
        chk("t1_run", 32'(SPIClkRunning), 32'h1);
        Req           = 2'b00;
        ReqSel        = 2'b00;
        ReqDo         = 2'b00;
        ReqClkRunning = 2'b00;
        tick();
        tick();
        tick();

        // fresh reset, then simultaneous requests
        Reset = 1'b1;
        #1;
        Reset = 1'b0;
        Req = 2'b11;
        tick();
        chk("t2_grant0", 32'(Grant), 32'h1);
        Req = 2'b10;
        tick();
        chk("t2_gap_a", 32'(Grant), 32'h0);
        chk("t2_gap_a_ns", 32'(nMCUSel), 32'h1);
        tick();
        chk("t2_gap_b", 32'(Grant), 32'h0);
        chk("t2_gap_b_ns", 32'(nMCUSel), 32'h1);
        tick();
        chk("t2_idle", 32'(Grant), 32'h0);
        chk("t2_idle_ns", 32'(nMCUSel), 32'h1);
        tick();
        chk("t2_grant1", 32'(Grant), 32'h2);
        chk("t2_owner1", 32'(Owner), 32'h1);
        Req = 2'b11;
        tick();
        chk("t2_nopre_a", 32'(Grant), 32'h2);
        tick();
        chk("t2_nopre_b", 32'(Grant), 32'h2);

        // owner 1 leaves with 0 pending: wrap to 0
        Req = 2'b01;
        tick();
        tick();
        tick();
        chk("t3_gap", 32'(Grant), 32'h0);
        tick();
        chk("t3_grant0", 32'(Grant), 32'h1);
        chk("t3_owner0", 32'(Owner), 32'h0);

        // 7 stretch, 1 low, 7 stretch: no timeout
        ReqClkStretch = 2'b01;
        #1;
        chk("t4_str_mux", 32'(SPIClkStretch), 32'h1);
        for (int i = 0; i < 7; i++) tick();
        chk("t4_7_grant", 32'(Grant), 32'h1);
        chk("t4_7_err", 32'(TimeoutErr), 32'h0);
        ReqClkStretch = 2'b00;
        tick();
        ReqClkStretch = 2'b01;
        for (int i = 0; i < 7; i++) tick();
        chk("t4_14_grant", 32'(Grant), 32'h1);
        chk("t4_14_err", 32'(TimeoutErr), 32'h0);
        // eighth consecutive stretch edge fires the watchdog
        tick();
        chk("t4_to_err", 32'(TimeoutErr), 32'h1);
        chk("t4_to_grant", 32'(Grant), 32'h0);
        chk("t4_to_str", 32'(SPIClkStretch), 32'h0);
        chk("t4_to_nsel", 32'(nMCUSel), 32'h1);
        ReqClkStretch = 2'b00;
        tick();
        chk("t4_sticky", 32'(TimeoutErr), 32'h1);
        ClearErr = 1'b1;
        tick();
        ClearErr = 1'b0;
        chk("t4_clear", 32'(TimeoutErr), 32'h0);
        chk("t4_idle", 32'(Grant), 32'h0);
        tick();
        chk("t4_regrant", 32'(Grant), 32'h1);

        // async reset while owning
        ReqSel = 2'b01;
        #1;
        chk("t5_nsel_lo", 32'(nMCUSel), 32'h0);
        Reset = 1'b1;
        #1;
        chk("t5_nsel_rst", 32'(nMCUSel), 32'h1);
        chk("t5_grant_rst", 32'(Grant), 32'h0);
        chk("t5_owner_rst", 32'(Owner), 32'h1);
        Reset  = 1'b0;
        ReqSel = 2'b00;
        Req    = 2'b10;
        tick();
        chk("t5_grant1", 32'(Grant), 32'h2);
        chk("t5_owner1", 32'(Owner), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
